// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch (IF) stage of the 5-stage MIPS R2000 pipeline.
//
// This stage owns the program counter and keeps at most one instruction-memory
// request outstanding. It loads the IF/ID register (pc_id, inst_id, valid_id)
// that decode reads. It also applies decode's stall and redirect requests, and
// raises flush_id to squash the wrong-path instruction.
//
// Ports:
//   clk, rst           clock (rising edge); asynchronous active-high reset
//   hold_pc, hold_if   stall requests from the decode hazard unit
//   br, pc_branch      taken branch/jump from decode and its target
//   imem_req/addr      memory request; held stable until imem_ready
//   imem_rdata/ready   memory response; ready may arrive in the request cycle
//   pc_id, inst_id     IF/ID register: fetch address + 4, instruction word
//   valid_id           IF/ID holds a real instruction (0 = bubble)
//   flush_id           one-cycle squash pulse, the cycle after br
//
// Build option: define IF_DELAY_SLOT_EN for architectural branch-delay-slot
// behaviour. In that mode the instruction in flight when br resolves is
// delivered instead of squashed. Without it, wrong-path fetches are squashed.

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold_pc,
    input  logic        hold_if,
    input  logic        br,
    input  logic [31:0] pc_branch,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc_id,
    output logic [31:0] inst_id,
    output logic        valid_id,
    output logic        flush_id
);

`ifdef IF_DELAY_SLOT_EN
    localparam logic DELAY_SLOT = 1'b1;
`else
    localparam logic DELAY_SLOT = 1'b0;
`endif

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_q, redir_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] inst_id_q, inst_id_d;
    logic        valid_id_q, valid_id_d;
    logic        flush_id_q, flush_id_d;

    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic        load_fetch;
    logic        load_bubble;

    assign pc_plus4  = pc_q + 32'd4;  // wraps modulo 2^32
    assign br_target = pc_branch & ALIGN_MASK;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redir_d     = redir_q;
        pc_id_d     = pc_id_q;
        inst_id_d   = inst_id_q;
        valid_id_d  = valid_id_q;
        flush_id_d  = 1'b0;
        load_fetch  = 1'b0;
        load_bubble = 1'b0;

        case (state_q)
            IDLE: begin
                state_d     = REQ;
                load_bubble = !hold_if;
                if (br) begin
                    pc_d       = br_target;
                    flush_id_d = !DELAY_SLOT;
                end
            end

            REQ: begin
                if (br) begin
                    flush_id_d = !DELAY_SLOT;
                    if (imem_ready) begin
                        pc_d        = br_target;
                        load_fetch  = DELAY_SLOT;
                        load_bubble = !DELAY_SLOT;
                    end else begin
                        // The request cannot be withdrawn. Park the target
                        // until the stale response has drained.
                        redir_d     = br_target;
                        state_d     = DISCARD;
                        load_bubble = DELAY_SLOT ? !hold_if : 1'b1;
                    end
                end else if (hold_pc || hold_if) begin
                    // Either stall freezes the PC and drops the returned
                    // word. The same address is then fetched again.
                    load_bubble = !hold_if;
                end else if (imem_ready) begin
                    pc_d       = pc_plus4;
                    load_fetch = 1'b1;
                end else begin
                    load_bubble = 1'b1;
                end
            end

            DISCARD: begin
                // The newest redirect target always replaces the parked one.
                if (br) begin
                    redir_d    = br_target;
                    flush_id_d = !DELAY_SLOT;
                end
                // A delay-slot response must not be lost to a stall, so
                // completion waits until any hold is released.
                if (imem_ready && !(DELAY_SLOT && (hold_pc || hold_if))) begin
                    pc_d       = br ? br_target : redir_q;
                    state_d    = REQ;
                    load_fetch = DELAY_SLOT;
                end
                load_bubble = !load_fetch && !hold_if;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_fetch) begin
            pc_id_d    = pc_plus4;
            inst_id_d  = imem_rdata;
            valid_id_d = 1'b1;
        end else if (load_bubble) begin
            inst_id_d  = NOP_WORD;
            valid_id_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC & ALIGN_MASK;
            redir_q    <= '0;
            pc_id_q    <= '0;
            inst_id_q  <= NOP_WORD;
            valid_id_q <= 1'b0;
            flush_id_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redir_q    <= redir_d;
            pc_id_q    <= pc_id_d;
            inst_id_q  <= inst_id_d;
            valid_id_q <= valid_id_d;
            flush_id_q <= flush_id_d;
        end
    end

    assign imem_req  = (state_q != IDLE);
    assign imem_addr = pc_q;
    assign pc_id     = pc_id_q;
    assign inst_id   = inst_id_q;
    assign valid_id  = valid_id_q;
    assign flush_id  = flush_id_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage (IF) of the 5-stage MIPS R2000 pipeline, directly upstream of the decode stage.
- Owns the program counter and drives a single-outstanding-request instruction-memory handshake.
- Loads the IF/ID pipeline register (pc_id, inst_id) consumed by decode.
- Applies decode's stall (hold_pc, hold_if) and redirect (br, pc_branch) requests, and generates flush_id to squash wrong-path instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_WORD, 32'h0000_0000, instruction word inserted as a bubble (sll $0,$0,0).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
hold_pc  input  1  from decode hazard unit; PC must not advance.
hold_if  input  1  from decode hazard unit; IF/ID register keeps its contents.
br  input  1  from decode; taken branch or jump resolved this cycle.
pc_branch  input  32  redirect target, valid when br=1.
imem_req  output  1  instruction-memory request.
imem_addr  output  32  word-aligned fetch address.
imem_rdata  input  32  instruction word, valid when imem_ready=1.
imem_ready  input  1  completes the outstanding request this cycle.
pc_id  output  32  IF/ID register: fetch address + 4.
inst_id  output  32  IF/ID register: instruction word.
valid_id  output  1  IF/ID register holds a real (non-bubble) instruction.
flush_id  output  1  squash control for the instruction currently in ID.

Behaviour:
Reset values:
- pc = RESET_PC; state = IDLE.
- imem_req = 0; pc_id = 0; inst_id = NOP_WORD; valid_id = 0; flush_id = 0; redirect target register = 0.
- Reset is effective mid-transaction: any outstanding request is abandoned and its response is never consumed.

FSM:
- IDLE: imem_req = 0. Always moves to REQ on the next cycle.
- REQ: imem_req = 1, imem_addr = pc.
- DISCARD: imem_req = 1, imem_addr = the stale pc. Waits for imem_ready, then loads pc from the redirect register and returns to REQ.

Memory protocol:
- imem_req and imem_addr are held stable from assertion until imem_ready.
- Response latency is 0..N cycles; imem_ready may be high in the same cycle as the request.

Priority within REQ (per cycle): br > hold_pc/hold_if > imem_ready > wait.
- br=1 and imem_ready=1: pc <= pc_branch. IF/ID loads NOP_WORD with valid_id=0. Returned data is dropped.
- br=1 and imem_ready=0: latch pc_branch into the redirect register; go to DISCARD. IF/ID loads the bubble.
- hold_pc=1: pc unchanged; any returned data is dropped; the same address is re-requested.
- hold_if=1: IF/ID unchanged.
- imem_ready=1 (no br, no hold): pc <= pc + 4; pc_id <= pc + 4; inst_id <= imem_rdata; valid_id <= 1.
- imem_ready=0: IF/ID loads the bubble unless hold_if=1.

flush_id:
- Registered; asserted for exactly one cycle, the cycle after br=1.
- Covers the instruction that was in IF when the branch resolved.
- Also asserted while valid_id=0 is never required.

Arithmetic and boundary rules:
- pc + 4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); no exception is raised.
- pc[1:0] and pc_branch[1:0] are forced to 0.
- br while in DISCARD: the redirect register is overwritten with the newer pc_branch.
- Two successive br cycles: the last target wins.

Optional Feature:
IF_DELAY_SLOT_EN
- Defined: architectural MIPS branch delay slot. On br=1 the instruction being fetched in that cycle is still delivered with valid_id=1, and flush_id is not asserted. In DISCARD the pending response is delivered to IF/ID instead of being dropped. The redirect takes effect on the following fetch.
- Undefined: the squash behaviour described under Behaviour applies.

Test Plan:
1. Reset, imem_ready tied 1, memory word k = k:
   - addresses 0, 4, 8 are requested on consecutive cycles;
   - pc_id = 4, 8, 12 and inst_id = 0, 1, 2, with valid_id = 1.
2. imem_ready low 3 cycles on address 8:
   - imem_addr is stable at 8 throughout;
   - three bubbles are inserted (valid_id=0, inst_id=NOP);
   - then inst_id = 2 and pc_id = 12.
3. hold_pc = hold_if = 1 for 1 cycle at pc = 16:
   - IF/ID is unchanged;
   - address 16 is re-requested, and inst 4 is then delivered exactly once.
4. br=1, pc_branch = 32'h40 at pc = 12, ready=1:
   - flush_id pulses 1 cycle later;
   - next imem_addr = 32'h40;
   - address 12 never appears with valid_id=1.
5. br=1, pc_branch = 32'h80 while the request at 20 is pending:
   - FSM enters DISCARD; address 20 is held until ready, and its data is dropped;
   - next imem_addr = 32'h80.
6. rst asserted mid-wait at pc = 24:
   - all outputs take their reset values immediately;
   - after release, fetch restarts at RESET_PC, and the late imem_ready is ignored.
